logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit XOR glue cell used on the modboard CPLD.
- Applies a selectable bitwise operation to two WIDTH-bit operands, with an optional running XOR accumulator for checksum use.
- Result is presented through a one-deep valid/ready output register.
- Sits between the host-side bus latch and downstream CPLD logic.

Parameters:
WIDTH, 8, operand/result width in bits (1..32)
CNT_W, 16, width of accepted-transaction counter

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/op presented
in_ready  out  1  unit can accept this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  3  operation select
out_valid  out  1  result register holds valid data
out_ready  in  1  downstream accepts result
x  out  WIDTH  result
parity  out  1  XOR-reduction of x
err  out  1  result came from reserved op
acc  out  WIDTH  current accumulator value
count  out  CNT_W  accepted transactions since reset

Behaviour:
- Reset: rst_n low asynchronously clears every output register to zero: out_valid, x, parity, err, acc, count. in_ready is 1 immediately after reset.
- Accept: fire_in = in_valid & in_ready. in_ready = !out_valid | out_ready, so a result can be consumed and a new one captured in the same cycle. Throughput is 1/cycle.
- Latency: on fire_in at edge N, the result is visible from edge N (registered) and out_valid = 1 after that edge.
- Ops (encoding held in package):
  - 0 XOR: a^b
  - 1 XNOR: ~(a^b)
  - 2 AND: a&b
  - 3 OR: a|b
  - 4 ACC_XOR: acc_next = acc^a^b; x = acc_next
  - 5 ACC_CLR: acc_next = 0; x = 0
  - 6, 7 reserved: x = 0, err = 1, acc unchanged
  - err = 0 for ops 0..5.
- acc updates only on fire_in with op 4 or 5. It is never touched by stalls or non-accepted inputs.
- parity is registered together with x and equals ^x_next.
- count increments by 1 on every fire_in, including reserved ops. It wraps from 2^CNT_W-1 to 0 without saturation or flag.
- Stall: out_valid=1 & out_ready=0 holds x/parity/err stable and keeps in_ready = 0. Inputs are ignored (no acc/count change).
- Drain: out_ready=1 with no fire_in clears out_valid next edge. x keeps its last value (don't-care while out_valid = 0).
- Simultaneous out_ready & fire_in: new result replaces old. out_valid stays 1 with no bubble.
- Reset mid-operation: pending result is discarded, acc is lost, and no output pulse is generated on reset release.
- Inputs a/b/op are sampled only at fire_in. Values while in_valid=0 have no effect.

Decomposition:
- Package logic_unit_pkg:
  - op encodings OP_XOR..OP_ACC_CLR, and OP_RSV6/7
  - function logic_op(a,b,op,acc) returning {x,acc_next,err}, shared with the testbench model.
- One sub-module, hs_reg_slice:
  - generic DATA_W one-deep valid/ready register carrying {err,parity,x}
  - owns the in_ready/out_valid logic
- The top holds the acc and count registers and the op decode.

Test Plan:
- Reset, then op=0 a=8'hA5 b=8'h0F, out_ready=1 -> next edge x=8'hAA, parity=0, err=0, out_valid=1, count=1.
- op=1 a=8'hFF b=8'h00 -> x=8'h00, parity=0. Then op=3 a=8'h81 b=8'h02 -> x=8'h83, parity=1. Run back-to-back with out_ready=1 held -> no bubble, in_ready stays 1.
- op=5, then op=4 with (a,b) = (8'h12,8'h00), (8'h34,8'h00), (8'h00,8'h56) -> x/acc sequence 12, 26, 70. Follow with op=0 -> acc stays 8'h70.
- Stall: result pending, out_ready=0 for 3 cycles with in_valid=1 and changing a -> in_ready=0, x stable, count and acc unchanged. On release, exactly one new accept per cycle.
- op=6 a=8'hFF b=8'hFF -> x=0, err=1, acc unchanged, count incremented. Next op=0 -> err=0.
- Assert rst_n low asynchronously mid-stall with acc=8'h70 -> all outputs 0 before the next clk edge, out_valid=0 after release. With CNT_W=4, 16 accepts wrap count to 0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the logic_unit_pipe block: operation encodings,
//   the result bundle, and the combinational operation function. The
//   function works on MAX_W-bit operands; callers zero-extend their operands
//   and keep only the low WIDTH bits of the returned fields.
package logic_unit_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [2:0] {
        OP_XOR     = 3'd0,
        OP_XNOR    = 3'd1,
        OP_AND     = 3'd2,
        OP_OR      = 3'd3,
        OP_ACC_XOR = 3'd4,
        OP_ACC_CLR = 3'd5,
        OP_RSV6    = 3'd6,
        OP_RSV7    = 3'd7
    } op_e;

    typedef struct packed {
        logic [MAX_W-1:0] x;
        logic [MAX_W-1:0] acc_next;
        logic             err;
    } op_result_t;

    // acc_next always carries the value the accumulator should take if the
    // operation is accepted; non-accumulator ops return acc unchanged.
    function automatic op_result_t logic_op(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input op_e              op,
        input logic [MAX_W-1:0] acc
    );
        op_result_t r;
        r.x        = '0;
        r.acc_next = acc;
        r.err      = 1'b0;
        case (op)
            OP_XOR:     r.x = a ^ b;
            OP_XNOR:    r.x = ~(a ^ b);
            OP_AND:     r.x = a & b;
            OP_OR:      r.x = a | b;
            OP_ACC_XOR: begin
                r.acc_next = acc ^ a ^ b;
                r.x        = r.acc_next;
            end
            OP_ACC_CLR: begin
                r.acc_next = '0;
                r.x        = '0;
            end
            default:    r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_hs_reg_slice.sv
// hs_reg_slice
//   One-deep valid/ready register. A held word can be consumed and a new one
//   captured in the same cycle, giving full throughput without a bubble.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_data             word captured on in_valid & in_ready
//   out_valid/out_ready downstream handshake
//   out_data            registered word
module hs_reg_slice #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            // Drain: data is left as-is, only valid drops.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Registered bitwise logic unit with a running XOR accumulator and an
//   accepted-transaction counter, presented through a one-deep valid/ready
//   output register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   a, b, op            operands and operation select
//   out_valid/out_ready result handshake
//   x, parity, err      result, XOR-reduction of result, reserved-op flag
//   acc                 accumulator value
//   count               accepted transactions since reset (wrapping)
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             parity,
    output logic             err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] count
);

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;
    logic [MAX_W-1:0] acc_ext;
    op_result_t       res;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH+1:0] slice_in;
    logic [WIDTH+1:0] slice_out;
    logic             fire_in;
    logic             acc_op;
    logic             unused_res_hi;

    always_comb begin
        a_ext               = '0;
        b_ext               = '0;
        acc_ext             = '0;
        a_ext[WIDTH-1:0]    = a;
        b_ext[WIDTH-1:0]    = b;
        acc_ext[WIDTH-1:0]  = acc;
        res                 = logic_op(a_ext, b_ext, op_e'(op), acc_ext);
        x_next              = res.x[WIDTH-1:0];
        acc_next            = res.acc_next[WIDTH-1:0];
        slice_in            = {res.err, ^x_next, x_next};
        acc_op              = (op_e'(op) == OP_ACC_XOR) || (op_e'(op) == OP_ACC_CLR);
    end

    // Bits above WIDTH are discarded (XNOR sets them for narrow widths).
    assign unused_res_hi = ^{res.x, res.acc_next};

    assign fire_in = in_valid & in_ready;

    hs_reg_slice #(
        .DATA_W(WIDTH + 2)
    ) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (slice_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (slice_out)
    );

    assign err    = slice_out[WIDTH+1];
    assign parity = slice_out[WIDTH];
    assign x      = slice_out[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (fire_in) begin
            count <= count + CNT_W'(1);
            if (acc_op) begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = 3'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] x;
    logic             parity;
    logic             err;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic_unit_pipe #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x        (x),
        .parity   (parity),
        .err      (err),
        .acc      (acc),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus at the falling edge, then sample 1ns after
    // the following rising edge.
    task automatic step(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [2:0] top, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        a         = ta;
        b         = tb;
        op        = top;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (x !== 8'h00) begin n_fail++; $display("FAIL reset_x got=%h exp=00", x); end
        n_checks++; if ({parity, err} !== 2'b00) begin n_fail++; $display("FAIL reset_par_err got=%b exp=00", {parity, err}); end
        n_checks++; if (acc !== 8'h00) begin n_fail++; $display("FAIL reset_acc got=%h exp=00", acc); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_xor;
        step(1'b1, 8'hA5, 8'h0F, 3'd0, 1'b1);
        n_checks++; if (x !== 8'hAA) begin n_fail++; $display("FAIL xor_x got=%h exp=AA", x); end
        n_checks++; if ({parity, err} !== 2'b00) begin n_fail++; $display("FAIL xor_par_err got=%b exp=00", {parity, err}); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL xor_out_valid got=%b exp=1", out_valid); end
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL xor_count got=%0d exp=1", count); end
    endtask

    task automatic test_back_to_back;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready0 got=%b exp=1", in_ready); end
        step(1'b1, 8'hFF, 8'h00, 3'd1, 1'b1);
        n_checks++; if ({x, parity} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL xnor_x_par got=%h/%b exp=00/0", x, parity); end
        n_checks++; if ({out_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_handshake1 got=%b exp=11", {out_valid, in_ready}); end
        step(1'b1, 8'h81, 8'h02, 3'd3, 1'b1);
        n_checks++; if ({x, parity} !== {8'h83, 1'b1}) begin n_fail++; $display("FAIL or_x_par got=%h/%b exp=83/1", x, parity); end
        n_checks++; if ({out_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_handshake2 got=%b exp=11", {out_valid, in_ready}); end
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", count); end
    endtask

    task automatic test_accumulate;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] ve [3];
        va = '{8'h12, 8'h34, 8'h00};
        vb = '{8'h00, 8'h00, 8'h56};
        ve = '{8'h12, 8'h26, 8'h70};
        step(1'b1, 8'h5A, 8'hC3, 3'd5, 1'b1);
        n_checks++; if ({x, acc} !== 16'h0000) begin n_fail++; $display("FAIL acc_clr got x=%h acc=%h exp=00/00", x, acc); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, va[i], vb[i], 3'd4, 1'b1);
            n_checks++;
            if (x !== ve[i] || acc !== ve[i]) begin
                n_fail++; $display("FAIL acc_xor_%0d got x=%h acc=%h exp=%h", i, x, acc, ve[i]);
            end
        end
        step(1'b1, 8'h01, 8'h02, 3'd0, 1'b1);
        n_checks++; if ({x, acc} !== {8'h03, 8'h70}) begin n_fail++; $display("FAIL acc_hold got x=%h acc=%h exp=03/70", x, acc); end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL acc_count got=%0d exp=8", count); end
    endtask

    task automatic test_stall;
        logic [7:0] sa [3];
        sa = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, sa[i], 8'h00, 3'd4, 1'b0);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || x !== 8'h03 || count !== 4'd8 || acc !== 8'h70) begin
                n_fail++;
                $display("FAIL stall_%0d got rdy=%b ov=%b x=%h cnt=%0d acc=%h exp 0/1/03/8/70",
                         i, in_ready, out_valid, x, count, acc);
            end
        end
        step(1'b1, 8'h10, 8'h01, 3'd0, 1'b1);
        n_checks++; if ({x, parity, count} !== {8'h11, 1'b0, 4'd9}) begin n_fail++; $display("FAIL release1 got x=%h p=%b cnt=%0d exp 11/0/9", x, parity, count); end
        step(1'b1, 8'h20, 8'h00, 3'd0, 1'b1);
        n_checks++; if ({x, parity, count} !== {8'h20, 1'b1, 4'd10}) begin n_fail++; $display("FAIL release2 got x=%h p=%b cnt=%0d exp 20/1/10", x, parity, count); end
    endtask

    task automatic test_reserved;
        step(1'b1, 8'hFF, 8'hFF, 3'd6, 1'b1);
        n_checks++;
        if ({x, parity, err} !== {8'h00, 1'b0, 1'b1} || acc !== 8'h70 || count !== 4'd11) begin
            n_fail++; $display("FAIL rsv6 got x=%h p=%b e=%b acc=%h cnt=%0d exp 00/0/1/70/11", x, parity, err, acc, count);
        end
        step(1'b1, 8'h0F, 8'hF0, 3'd7, 1'b1);
        n_checks++;
        if ({x, err} !== {8'h00, 1'b1} || acc !== 8'h70 || count !== 4'd12) begin
            n_fail++; $display("FAIL rsv7 got x=%h e=%b acc=%h cnt=%0d exp 00/1/70/12", x, err, acc, count);
        end
        step(1'b1, 8'h07, 8'h00, 3'd0, 1'b1);
        n_checks++; if ({x, parity, err} !== {8'h07, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rsv_clear got x=%h p=%b e=%b exp 07/1/0", x, parity, err); end
    endtask

    task automatic test_drain;
        step(1'b0, 8'hEE, 8'hEE, 3'd4, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd13 || acc !== 8'h70) begin
            n_fail++; $display("FAIL drain got ov=%b rdy=%b cnt=%0d acc=%h exp 0/1/13/70", out_valid, in_ready, count, acc);
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 8'h0F, 8'h00, 3'd0, 1'b0);
        n_checks++; if ({out_valid, x, count} !== {1'b1, 8'h0F, 4'd14}) begin n_fail++; $display("FAIL pre_rst got ov=%b x=%h cnt=%0d exp 1/0F/14", out_valid, x, count); end
        step(1'b1, 8'h55, 8'h00, 3'd4, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, x, parity, err, acc, count} !== '0) begin
            n_fail++; $display("FAIL async_rst got ov=%b x=%h p=%b e=%b acc=%h cnt=%0d exp all 0",
                               out_valid, x, parity, err, acc, count);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if ({out_valid, count} !== {1'b0, 4'd0}) begin n_fail++; $display("FAIL post_rst got ov=%b cnt=%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_count_wrap;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 8'h00, 3'd0, 1'b1);
            if (i == 15) begin
                n_checks++; if (count !== 4'd15) begin n_fail++; $display("FAIL count_15 got=%0d exp=15", count); end
            end
        end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL count_wrap got=%0d exp=0", count); end
        n_checks++; if (x !== 8'h10) begin n_fail++; $display("FAIL wrap_x got=%h exp=10", x); end
    endtask

    initial begin
        test_reset();
        test_basic_xor();
        test_back_to_back();
        test_accumulate();
        test_stall();
        test_reserved();
        test_drain();
        test_async_reset();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
